rs_deinterleaver: RTL
=====================

Name: rs_deinterleaver

Overview:
- Takes the byte stream of one CVCDU (1020 bytes = 4 interleaved RS(255,223) codewords, interleaving depth 4) from the derandomiser/frame-sync stage.
- Splits the CVCDU into its 4 codewords in a frame buffer, then streams them out one whole codeword at a time (codeword 0 first) to the RS decoder.
- The rs_reinterleaver stage downstream of the RS decoder restores the original interleaved byte order.

Parameters:
- INTERLEAVE_DEPTH, 4, number of interleaved codewords per CVCDU.
- CODEWORD_LEN, 255, bytes per RS codeword.
- Derived, not overridable: FRAME_LEN = INTERLEAVE_DEPTH*CODEWORD_LEN = 1020.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- in_data  input  8  CVCDU byte.
- in_valid  input  1  in_data valid.
- in_sof  input  1  qualifies in_data as byte 0 of a new CVCDU.
- in_ready  output  1  block accepts a byte this cycle.
- out_data  output  8  codeword byte.
- out_cw_idx  output  2  codeword index (0..3) of out_data.
- out_valid  output  1  out_data valid.
- out_last  output  1  out_data is byte 254 of its codeword.
- out_ready  input  1  downstream accepts out_data.
- frame_done  output  1  one-cycle pulse after the final output byte of a CVCDU.
- short_frame  output  1  one-cycle pulse when a partial CVCDU is discarded.

Behaviour:
- Clock and reset: one clock (clk_in). Reset is synchronous, active-high (rst_in).
- Reset, applied in any state:
  - All outputs go to 0 and the state goes to IDLE.
  - Counters clear and buffer contents are don't-care.
  - in_ready rises to 1 on the first cycle after rst_in deasserts.
- Transfer rule: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- State IDLE:
  - in_ready=1.
  - A transfer with in_sof=0 is dropped.
  - A transfer with in_sof=1 writes byte k=0 and goes to FILL with k=1.
- State FILL:
  - in_ready=1.
  - Transfer k is written to buffer address (k mod 4)*255 + (k div 4).
  - If in_sof=1 on a transfer while k>0: pulse short_frame, discard the partial frame, write this byte as k=0, stay in FILL with k=1.
  - The transfer with k=1019 moves the block to DRAIN on the next cycle; in_ready=0 from that cycle.
- State DRAIN:
  - in_ready=0.
  - Reads addresses 0..1019 sequentially and presents them as AXI-stream-style output.
  - out_data, out_cw_idx and out_last are stable while out_valid=1 and out_ready=0.
  - out_valid must not drop without an output transfer.
  - out_cw_idx = addr div 255. out_last=1 when addr mod 255 = 254.
  - Throughput: 1 byte/cycle while out_ready=1.
  - First out_valid no later than 3 cycles after entering DRAIN.
- DRAIN exit:
  - The output transfer at address 1019 returns the block to IDLE.
  - frame_done pulses on the cycle following that transfer.
  - in_ready=1 on that same cycle.
- Counters: the write counter is 10 bits, 0..1019, and never wraps past 1019. The read address is 10 bits; codeword index and position are tracked by separate counters (0..3 and 0..254), so no divider is needed.
- Buffer: single 1020x8 synchronous RAM inferred as BRAM, 1 read port and 1 write port. Writes and reads never overlap, because FILL and DRAIN are exclusive.
- Out-of-band inputs: in_valid, in_sof and in_data are ignored while in_ready=0. No byte is lost because upstream must hold on !in_ready.

Optional Feature:
- Macro: RS_DEINT_STATS_EN.
- When defined:
  - Adds output port frames_ok (16 bits): counts frame_done pulses.
  - Adds output port frames_short (16 bits): counts short_frame pulses.
  - Both saturate at 16'hFFFF and clear on rst_in.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Full frame: in_sof on k=0, byte value = k mod 256, out_ready=1 -> exactly 1020 outputs.
  - Codeword 0 = 0,4,8,...,248 (byte 254 = 1016 mod 256).
  - Codeword 1 starts 1,5. Codeword 3 ends 251.
  - out_last on output indices 254, 509, 764, 1019.
  - frame_done one cycle after the last output.
- Backpressure: same frame, out_ready toggles with 1-in-3 high -> identical byte sequence, data held stable while stalled, no loss or duplication.
- Short frame: 300 bytes, then in_sof with a new 1020-byte frame -> one short_frame pulse; output holds only the second frame's bytes.
- Junk before sync: 10 bytes with in_sof=0 in IDLE, then a valid frame -> junk dropped; output matches scenario 1.
- Input during drain: hold in_valid=1 during DRAIN -> in_ready=0; no buffer corruption; next frame accepted after frame_done.
- Reset mid-drain: assert rst_in at output byte 500 -> next cycle out_valid=0, in_ready=0; in_ready=1 after release; a fresh frame decodes correctly. With RS_DEINT_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/rs_deinterleaver.sv
// rs_deinterleaver: splits one CVCDU (INTERLEAVE_DEPTH interleaved RS codewords)
// into whole codewords. Bytes are written de-interleaved into a frame buffer
// during FILL, then the buffer is streamed out in address order during DRAIN.
// Optional build macro RS_DEINT_STATS_EN adds saturating frame counters
// (frames_ok, frames_short).
module rs_deinterleaver #(
   parameter int INTERLEAVE_DEPTH = 4,
   parameter int CODEWORD_LEN     = 255
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic [1:0]  out_cw_idx,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
`ifdef RS_DEINT_STATS_EN
   output logic [15:0] frames_ok,
   output logic [15:0] frames_short,
`endif
   output logic        frame_done,
   output logic        short_frame
);

   localparam int FRAME_LEN = INTERLEAVE_DEPTH * CODEWORD_LEN;
   localparam int AW        = $clog2(FRAME_LEN);
   localparam int LW        = $clog2(INTERLEAVE_DEPTH);
   localparam int CW        = $clog2(CODEWORD_LEN);

   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
   localparam logic [AW-1:0] CW_STEP   = AW'(CODEWORD_LEN);
   localparam logic [LW-1:0] LAST_LANE = LW'(INTERLEAVE_DEPTH - 1);
   localparam logic [CW-1:0] LAST_POS  = CW'(CODEWORD_LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t        state_reg, state_next;
   logic          in_ready_reg, in_ready_next;
   logic          done_reg, done_next;
   logic          short_reg, short_next;

   // write side: k counts accepted bytes, lane/col locate the byte inside the
   // codeword matrix, wr_addr = lane*CODEWORD_LEN + col kept incrementally
   logic [AW-1:0] k_reg, k_next;
   logic [LW-1:0] lane_reg, lane_next;
   logic [CW-1:0] col_reg, col_next;
   logic [AW-1:0] wr_addr_reg, wr_addr_next;

   // read side: linear address plus separate codeword/position counters
   logic [AW-1:0] rd_addr_reg, rd_addr_next;
   logic [LW-1:0] rd_cw_reg, rd_cw_next;
   logic [CW-1:0] rd_pos_reg, rd_pos_next;
   logic          rd_done_reg, rd_done_next;

   // tags travelling with the byte held in the RAM read register
   logic          out_valid_reg, out_valid_next;
   logic [1:0]    out_cw_reg, out_cw_next;
   logic          out_last_reg, out_last_next;
   logic          out_end_reg, out_end_next;

   logic          in_fire;
   logic          wr_en;
   logic [AW-1:0] wr_addr_sel;
   logic          rd_en;

   logic [7:0]    mem [FRAME_LEN];
   logic [7:0]    rd_data_reg;

   assign in_fire = in_valid & in_ready_reg;

   // next-state, counters and buffer control
   always_comb begin
      state_next     = state_reg;
      in_ready_next  = in_ready_reg;
      done_next      = 1'b0;
      short_next     = 1'b0;
      k_next         = k_reg;
      lane_next      = lane_reg;
      col_next       = col_reg;
      wr_addr_next   = wr_addr_reg;
      rd_addr_next   = rd_addr_reg;
      rd_cw_next     = rd_cw_reg;
      rd_pos_next    = rd_pos_reg;
      rd_done_next   = rd_done_reg;
      out_valid_next = out_valid_reg;
      out_cw_next    = out_cw_reg;
      out_last_next  = out_last_reg;
      out_end_next   = out_end_reg;
      wr_en          = 1'b0;
      wr_addr_sel    = wr_addr_reg;
      rd_en          = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready_next = 1'b1;
            if (in_fire && in_sof) begin
               wr_en        = 1'b1;
               wr_addr_sel  = '0;
               state_next   = FILL;
               k_next       = AW'(1);
               lane_next    = LW'(1);
               col_next     = '0;
               wr_addr_next = CW_STEP;
            end
         end

         FILL: begin
            in_ready_next = 1'b1;
            if (in_fire) begin
               wr_en = 1'b1;
               if (in_sof) begin
                  // a new sync mid-frame restarts the frame at byte 0
                  short_next   = 1'b1;
                  wr_addr_sel  = '0;
                  k_next       = AW'(1);
                  lane_next    = LW'(1);
                  col_next     = '0;
                  wr_addr_next = CW_STEP;
               end else if (k_reg == LAST_ADDR) begin
                  state_next    = DRAIN;
                  in_ready_next = 1'b0;
                  rd_addr_next  = '0;
                  rd_cw_next    = '0;
                  rd_pos_next   = '0;
                  rd_done_next  = 1'b0;
               end else begin
                  k_next = k_reg + AW'(1);
                  if (lane_reg == LAST_LANE) begin
                     lane_next    = '0;
                     col_next     = col_reg + CW'(1);
                     wr_addr_next = AW'(col_reg) + AW'(1);
                  end else begin
                     lane_next    = lane_reg + LW'(1);
                     wr_addr_next = wr_addr_reg + CW_STEP;
                  end
               end
            end
         end

         DRAIN: begin
            in_ready_next = 1'b0;
            // the read register only advances when it is empty or being taken
            if (!out_valid_reg || out_ready) begin
               if (!rd_done_reg) begin
                  rd_en          = 1'b1;
                  out_valid_next = 1'b1;
                  out_cw_next    = 2'(rd_cw_reg);
                  out_last_next  = (rd_pos_reg == LAST_POS);
                  out_end_next   = (rd_addr_reg == LAST_ADDR);
                  rd_addr_next   = rd_addr_reg + AW'(1);
                  if (rd_addr_reg == LAST_ADDR)
                     rd_done_next = 1'b1;
                  if (rd_pos_reg == LAST_POS) begin
                     rd_pos_next = '0;
                     rd_cw_next  = rd_cw_reg + LW'(1);
                  end else begin
                     rd_pos_next = rd_pos_reg + CW'(1);
                  end
               end else begin
                  out_valid_next = 1'b0;
               end
            end
            if (out_valid_reg && out_ready && out_end_reg) begin
               state_next     = IDLE;
               in_ready_next  = 1'b1;
               done_next      = 1'b1;
               out_valid_next = 1'b0;
               rd_addr_next   = '0;
               rd_cw_next     = '0;
               rd_pos_next    = '0;
               rd_done_next   = 1'b0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // state and counter registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b0;
         done_reg      <= 1'b0;
         short_reg     <= 1'b0;
         k_reg         <= '0;
         lane_reg      <= '0;
         col_reg       <= '0;
         wr_addr_reg   <= '0;
         rd_addr_reg   <= '0;
         rd_cw_reg     <= '0;
         rd_pos_reg    <= '0;
         rd_done_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_cw_reg    <= '0;
         out_last_reg  <= 1'b0;
         out_end_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         in_ready_reg  <= in_ready_next;
         done_reg      <= done_next;
         short_reg     <= short_next;
         k_reg         <= k_next;
         lane_reg      <= lane_next;
         col_reg       <= col_next;
         wr_addr_reg   <= wr_addr_next;
         rd_addr_reg   <= rd_addr_next;
         rd_cw_reg     <= rd_cw_next;
         rd_pos_reg    <= rd_pos_next;
         rd_done_reg   <= rd_done_next;
         out_valid_reg <= out_valid_next;
         out_cw_reg    <= out_cw_next;
         out_last_reg  <= out_last_next;
         out_end_reg   <= out_end_next;
      end
   end

   // frame buffer write port
   always_ff @(posedge clk_in) begin
      if (wr_en)
         mem[wr_addr_sel] <= in_data;
   end

   // frame buffer registered read port; holds its value while stalled
   always_ff @(posedge clk_in) begin
      if (rd_en)
         rd_data_reg <= mem[rd_addr_reg];
   end

   // the read register is uninitialised after reset, so data is masked by valid
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_out_mask
         assign out_data[gi] = rd_data_reg[gi] & out_valid_reg;
      end
   endgenerate

   assign in_ready    = in_ready_reg;
   assign out_valid   = out_valid_reg;
   assign out_cw_idx  = out_cw_reg;
   assign out_last    = out_last_reg;
   assign frame_done  = done_reg;
   assign short_frame = short_reg;

`ifdef RS_DEINT_STATS_EN
   logic [15:0] frames_ok_reg;
   logic [15:0] frames_short_reg;

   // saturating counts of completed and discarded frames
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         frames_ok_reg    <= '0;
         frames_short_reg <= '0;
      end else begin
         if (done_next && frames_ok_reg != 16'hFFFF)
            frames_ok_reg <= frames_ok_reg + 16'd1;
         if (short_next && frames_short_reg != 16'hFFFF)
            frames_short_reg <= frames_short_reg + 16'd1;
      end
   end

   assign frames_ok    = frames_ok_reg;
   assign frames_short = frames_short_reg;
`endif

endmodule
